// File: rtl/bus_decoder_if.sv
// Master-side request/response bus plus the per-device fan-out of a bus_decoder.
// The decoder connects through the slave modport; the requester/devices use master.
interface bus_decoder_if #(
    parameter int N_DEV = 5,
    parameter int DW    = 32,
    parameter int AW    = 32
);
    logic                   i_req;
    logic [AW-1:0]          i_addr;
    logic [N_DEV-1:0]       o_sel;
    logic [N_DEV*DW-1:0]    i_dev_rdata;
    logic [N_DEV-1:0]       i_dev_ready;
    logic [DW-1:0]          o_rdata;
    logic                   o_ready;
    logic                   o_err;
    logic                   o_busy;

    modport slave (
        input  i_req, i_addr, i_dev_rdata, i_dev_ready,
        output o_sel, o_rdata, o_ready, o_err, o_busy
    );

    modport master (
        output i_req, i_addr, i_dev_rdata, i_dev_ready,
        input  o_sel, o_rdata, o_ready, o_err, o_busy
    );
endinterface

// File: rtl/bus_decoder.sv
// Address-decoding single-outstanding bus bridge: routes one request to the device
// whose 4-bit ID matches the address top nibble, waits for its ready or a timeout.
module bus_decoder_slot #(
    parameter logic [3:0] ID = 4'h0
) (
    input  logic [3:0] id,
    output logic       hit
);
    assign hit = (id == ID);
endmodule

module bus_decoder #(
    parameter int                 N_DEV   = 5,
    parameter int                 DW      = 32,
    parameter int                 AW      = 32,
    parameter logic [4*N_DEV-1:0] DEV_IDS = {4'h8, 4'h6, 4'h5, 4'h4, 4'h0},
    parameter int                 TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    bus_decoder_if.slave   bus
);
    localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]       state;
    logic [IW-1:0]    target;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    rdata;

    logic [3:0]       req_id;
    logic [N_DEV-1:0] hit;
    logic             any_hit;
    logic [IW-1:0]    hit_idx;
    logic             tgt_ready;
    logic [DW-1:0]    tgt_data;
    logic [N_DEV-1:0] sel;

    assign req_id = bus.i_addr[AW-1:AW-4];

    for (genvar k = 0; k < N_DEV; k++) begin : g_slot
        bus_decoder_slot #(.ID(DEV_IDS[4*k +: 4])) u_slot (
            .id  (req_id),
            .hit (hit[k])
        );
    end

    // Walk downwards so the lowest matching slot wins when IDs are duplicated.
    always_comb begin
        hit_idx = '0;
        any_hit = |hit;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            if (hit[k]) hit_idx = IW'(k);
        end
    end

    always_comb begin
        tgt_ready = 1'b0;
        tgt_data  = '0;
        sel       = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (target == IW'(k)) begin
                tgt_ready = bus.i_dev_ready[k];
                tgt_data  = bus.i_dev_rdata[DW*k +: DW];
                sel[k]    = (state == S_WAIT);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            target <= '0;
            cnt    <= '0;
            rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_req) begin
                        if (any_hit) begin
                            target <= hit_idx;
                            cnt    <= '0;
                            state  <= S_WAIT;
                        end else begin
                            rdata <= '0;
                            state <= S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    // Ready is checked first so a same-cycle ready beats the timeout.
                    if (tgt_ready) begin
                        rdata <= tgt_data;
                        state <= S_RESP;
                    end else if (TIMEOUT > 0 && cnt == TO_VAL) begin
                        rdata <= '0;
                        state <= S_ERR;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_sel   = sel;
    assign bus.o_rdata = rdata;
    assign bus.o_ready = (state == S_RESP) || (state == S_ERR);
    assign bus.o_err   = (state == S_ERR);
    assign bus.o_busy  = (state != S_IDLE);
endmodule
